subleq_mem_bridge: RTL and testbench
====================================

# subleq_mem_bridge

Memory-side agent for the SUBLEQ processor bus. Accepts single-word read/write requests, serves them from an internal synchronous RAM, and maps two addresses onto simple I/O ports (output latch and input handshake). It sits directly downstream of the processor core and returns the data-valid flag the core's control sequencer waits on.

## Interface
- DATA_ADDR_WIDTH, 16: address and data word width.
- MEM_DEPTH, 256: RAM words, at addresses 0..MEM_DEPTH-1; must be ≤ IO_OUT_ADDR.
- IO_OUT_ADDR, 16'hFFFE: address of the memory-mapped output latch.
- IO_IN_ADDR, 16'hFFFF: address of the memory-mapped input port.

Ports:
- CLOCK  in  1  single clock; all state changes on its rising edge.
- RESET_bar  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  request present; held with the other REQ_* signals until RSP_VALID.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  DATA_ADDR_WIDTH  word address.
- REQ_WDATA  in  DATA_ADDR_WIDTH  write data.
- RSP_VALID  out  1  one-cycle pulse; request complete.
- RSP_RDATA  out  DATA_ADDR_WIDTH  read data, or echo of write data; held until the next response.
- IO_OUT  out  DATA_ADDR_WIDTH  output latch value.
- IO_OUT_STB  out  1  one-cycle pulse when IO_OUT is updated.
- IO_IN  in  DATA_ADDR_WIDTH  external input word.
- IO_IN_VALID  in  1  IO_IN holds a new word.
- IO_IN_ACK  out  1  one-cycle pulse; IO_IN word consumed.

## Operation
- FSM states: IDLE, ACCESS, IO_WAIT, RSP.
- **IDLE:** when REQ_VALID=1, latch REQ_WRITE, REQ_ADDR and REQ_WDATA, then decode:
  - RAM range, write: the RAM word is written at the accepting edge. Go to ACCESS.
  - RAM range, read: go to ACCESS, where the RAM output is registered.
  - IO_OUT_ADDR, write: IO_OUT←WDATA and IO_OUT_STB=1 on the next cycle. Go to ACCESS.
  - IO_OUT_ADDR, read: returns the current IO_OUT. Go to ACCESS.
  - IO_IN_ADDR, read: go to IO_WAIT.
  - IO_IN_ADDR, write: ignored. Go to ACCESS.
  - Any other address: reads return 0, writes are ignored. Go to ACCESS.
- **ACCESS:** always go to RSP.
- **IO_WAIT:** stay until IO_IN_VALID=1. Then capture IO_IN into RSP_RDATA, pulse IO_IN_ACK in the following cycle, and go to RSP.
- **RSP:** RSP_VALID=1 for exactly one cycle, then go to IDLE.
- REQ_VALID is ignored outside IDLE.
- RAM contents are not reset; a RAM read before any write returns X.
- Arithmetic: none; address compare is full-width and unsigned.

## Timing
- Request accepted at edge N (state IDLE, REQ_VALID=1).
- RAM or other non-IO_IN access: RSP_VALID is high in the cycle after edge N+1, so fixed latency is 2 cycles.
- IO_IN read: RSP_VALID and IO_IN_ACK are both high in the cycle after the edge that samples IO_IN_VALID=1 in IO_WAIT.
- Minimum request spacing is 3 cycles (IDLE→ACCESS→RSP→IDLE).
- REQ_VALID still high in the IDLE cycle after RSP is a new request. Requesters must drop or change it when RSP_VALID is seen.
- RAM write and read to the same address in consecutive requests: the read returns the new value.
- Reset values: state=IDLE, RSP_VALID=0, RSP_RDATA=0, IO_OUT=0, IO_OUT_STB=0, IO_IN_ACK=0.
- Reset asserted mid-transaction (any state): abandon the access, go to IDLE next edge, emit no RSP_VALID. A RAM write already performed stays. IO_OUT is cleared to 0.
- IO_IN_VALID high while not in IO_WAIT: no effect, no ACK.

## Structure
- Shared package: FSM state encoding (2 bits) and the default IO_OUT_ADDR / IO_IN_ADDR constants, so the core's test programs use the same addresses.
- Sub-module: `sync_ram`, a single-port synchronous RAM (one write port, registered read) parameterised by width and depth. Everything else, including address decode, FSM and I/O registers, lives in the top level.

## Test plan
- Reset, then idle 5 cycles: RSP_VALID, IO_OUT_STB and IO_IN_ACK stay 0; IO_OUT=0.
- Write 16'h1234 to addr 5, then read addr 5: each RSP_VALID pulses 2 cycles after acceptance; the read returns 16'h1234.
- Write 16'hBEEF to IO_OUT_ADDR: IO_OUT=16'hBEEF with a one-cycle IO_OUT_STB. A later read of IO_OUT_ADDR returns 16'hBEEF.
- Read IO_IN_ADDR with IO_IN_VALID held low 10 cycles, then raised with IO_IN=16'h00A5: no response while waiting; then RSP_RDATA=16'h00A5 with RSP_VALID and IO_IN_ACK together, once.
- Read addr 16'h8000 (unmapped, MEM_DEPTH=256): RSP_RDATA=0 after 2 cycles. Write addr 16'h8000: RAM is unchanged and still acknowledged.
- Assert RESET_bar=0 during IO_WAIT, release, then read addr 5 (written 16'h1234 earlier): no stray response, state returns to IDLE, the read returns 16'h1234.

Source files
------------

// File: rtl/subleq_mem_bridge_pkg.sv
// subleq_mem_bridge_pkg: bridge FSM encoding and the I/O addresses shared with the core's test programs.
package subleq_mem_bridge_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACCESS  = 2'd1;
  localparam state_t ST_IO_WAIT = 2'd2;
  localparam state_t ST_RSP     = 2'd3;
  localparam logic [15:0] DEF_IO_OUT_ADDR = 16'hFFFE;
  localparam logic [15:0] DEF_IO_IN_ADDR  = 16'hFFFF;
endpackage

// File: rtl/sync_ram.sv
// sync_ram: single-port RAM with one write port and a registered read, no reset on contents.
module sync_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             q
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end
endmodule

// File: rtl/subleq_mem_bridge.sv
// subleq_mem_bridge: SUBLEQ bus memory agent serving RAM plus a memory-mapped output latch and input port.
module subleq_mem_bridge
  import subleq_mem_bridge_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int MEM_DEPTH       = 256,
  parameter logic [DATA_ADDR_WIDTH-1:0] IO_OUT_ADDR = DATA_ADDR_WIDTH'(DEF_IO_OUT_ADDR),
  parameter logic [DATA_ADDR_WIDTH-1:0] IO_IN_ADDR  = DATA_ADDR_WIDTH'(DEF_IO_IN_ADDR)
) (
  input  logic                       CLOCK,
  input  logic                       RESET_bar,
  input  logic                       REQ_VALID,
  input  logic                       REQ_WRITE,
  input  logic [DATA_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_ADDR_WIDTH-1:0] REQ_WDATA,
  output logic                       RSP_VALID,
  output logic [DATA_ADDR_WIDTH-1:0] RSP_RDATA,
  output logic [DATA_ADDR_WIDTH-1:0] IO_OUT,
  output logic                       IO_OUT_STB,
  input  logic [DATA_ADDR_WIDTH-1:0] IO_IN,
  input  logic                       IO_IN_VALID,
  output logic                       IO_IN_ACK
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [DATA_ADDR_WIDTH:0] DEPTH_W = (DATA_ADDR_WIDTH+1)'(MEM_DEPTH);
  state_t state;
  logic wr;
  logic [DATA_ADDR_WIDTH-1:0] addr, wdata, ram_q;
  logic req_ram, lat_ram, ram_we;
  assign req_ram   = {1'b0, REQ_ADDR} < DEPTH_W;
  assign lat_ram   = {1'b0, addr} < DEPTH_W;
  assign ram_we    = RESET_bar && state == ST_IDLE && REQ_VALID && REQ_WRITE && req_ram;
  assign RSP_VALID = state == ST_RSP;
  // RAM is addressed straight from the bus so its registered output is ready in ACCESS
  sync_ram #(.W(DATA_ADDR_WIDTH), .DEPTH(MEM_DEPTH)) u_ram (
    .clk(CLOCK), .we(ram_we), .addr(REQ_ADDR[AW-1:0]), .wdata(REQ_WDATA), .q(ram_q)
  );
  always_ff @(posedge CLOCK) begin
    if (state == ST_IDLE && REQ_VALID) begin
      wr    <= REQ_WRITE;
      addr  <= REQ_ADDR;
      wdata <= REQ_WDATA;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (!RESET_bar) begin
      state      <= ST_IDLE;
      RSP_RDATA  <= '0;
      IO_OUT     <= '0;
      IO_OUT_STB <= 1'b0;
      IO_IN_ACK  <= 1'b0;
    end else begin
      IO_OUT_STB <= 1'b0;
      IO_IN_ACK  <= 1'b0;
      case (state)
        ST_IDLE: if (REQ_VALID) begin
          if (REQ_WRITE && REQ_ADDR == IO_OUT_ADDR) begin
            IO_OUT     <= REQ_WDATA;
            IO_OUT_STB <= 1'b1;
          end
          state <= (!REQ_WRITE && REQ_ADDR == IO_IN_ADDR) ? ST_IO_WAIT : ST_ACCESS;
        end
        ST_ACCESS: begin
          RSP_RDATA <= wr ? wdata : lat_ram ? ram_q : addr == IO_OUT_ADDR ? IO_OUT : '0;
          state     <= ST_RSP;
        end
        ST_IO_WAIT: if (IO_IN_VALID) begin
          RSP_RDATA <= IO_IN;
          IO_IN_ACK <= 1'b1;
          state     <= ST_RSP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subleq_mem_bridge.sv
// tb_subleq_mem_bridge: directed plus randomized requests checked against an array/latch model of the bus.
module tb_subleq_mem_bridge;
  logic CLOCK = 1'b0, RESET_bar = 1'b0;
  logic REQ_VALID = 1'b0, REQ_WRITE = 1'b0;
  logic [15:0] REQ_ADDR = '0, REQ_WDATA = '0, IO_IN = '0;
  logic IO_IN_VALID = 1'b0;
  logic RSP_VALID, IO_OUT_STB, IO_IN_ACK;
  logic [15:0] RSP_RDATA, IO_OUT;
  int n_tests = 0, n_fail = 0;
  logic [15:0] mem_m [256];
  bit known [256];
  logic [15:0] io_out_m = '0;

  subleq_mem_bridge dut (
    .CLOCK(CLOCK), .RESET_bar(RESET_bar), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .IO_OUT(IO_OUT), .IO_OUT_STB(IO_OUT_STB), .IO_IN(IO_IN), .IO_IN_VALID(IO_IN_VALID),
    .IO_IN_ACK(IO_IN_ACK)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Drive one request and watch the bus until the response (bounded), then return to IDLE.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] wd, input int io_delay,
                        input logic [15:0] io_word, output logic [15:0] rd, output int lat,
                        output int stbs, output int acks, output int acks_rsp);
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = wd; IO_IN = io_word;
    rd = '0; lat = 0; stbs = 0; acks = 0; acks_rsp = 0;
    for (int c = 0; c < 40; c++) begin
      IO_IN_VALID = c >= io_delay;
      tick();
      lat++;
      stbs += int'(IO_OUT_STB);
      acks += int'(IO_IN_ACK);
      if (RSP_VALID && IO_IN_ACK) acks_rsp++;
      if (RSP_VALID) begin
        rd = RSP_RDATA;
        break;
      end
    end
    REQ_VALID = 1'b0; IO_IN_VALID = 1'b0;
    tick();
    chk("rsp_single", RSP_VALID, 0);
    acks += int'(IO_IN_ACK);
  endtask

  task automatic transact(input logic w, input logic [15:0] a, input logic [15:0] wd,
                          input int io_delay, input logic [15:0] io_word);
    logic [15:0] rd, exp_rd;
    int lat, stbs, acks, acks_rsp, exp_lat;
    bit in_rd, ram, check_rd;
    ram      = a < 16'd256;
    in_rd    = !w && a == 16'hFFFF;
    exp_rd   = w ? wd : ram ? mem_m[a[7:0]] : a == 16'hFFFE ? io_out_m : in_rd ? io_word : 16'h0;
    exp_lat  = in_rd ? ((io_delay + 1 > 2) ? io_delay + 1 : 2) : 2;
    check_rd = !(!w && ram && !known[a[7:0]]);
    if (w && ram) begin mem_m[a[7:0]] = wd; known[a[7:0]] = 1'b1; end
    if (w && a == 16'hFFFE) io_out_m = wd;
    do_req(w, a, wd, io_delay, io_word, rd, lat, stbs, acks, acks_rsp);
    chk($sformatf("lat@%h", a), lat, exp_lat);
    if (check_rd) chk($sformatf("rdata@%h", a), rd, exp_rd);
    chk("io_out_stb", stbs, (w && a == 16'hFFFE) ? 1 : 0);
    chk("io_in_ack", acks, in_rd ? 1 : 0);
    chk("ack_with_rsp", acks_rsp, in_rd ? 1 : 0);
    chk("io_out", IO_OUT, io_out_m);
  endtask

  initial begin
    logic [15:0] a;
    repeat (3) tick();
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_rsp_rdata", RSP_RDATA, 0);
    chk("rst_io_out", IO_OUT, 0);
    chk("rst_io_out_stb", IO_OUT_STB, 0);
    chk("rst_io_in_ack", IO_IN_ACK, 0);
    RESET_bar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_quiet", {RSP_VALID, IO_OUT_STB, IO_IN_ACK}, 0);
      chk("idle_io_out", IO_OUT, 0);
    end
    transact(1, 16'd5, 16'h1234, 99, 16'h0);
    transact(0, 16'd5, 16'h0, 99, 16'h0);
    transact(1, 16'd0, 16'h0F0F, 99, 16'h0);
    transact(1, 16'hFFFE, 16'hBEEF, 99, 16'h0);
    transact(0, 16'hFFFE, 16'h0, 99, 16'h0);
    transact(0, 16'hFFFF, 16'h0, 10, 16'h00A5);
    transact(0, 16'h8000, 16'h0, 99, 16'h0);
    transact(1, 16'h8000, 16'hDEAD, 99, 16'h0);
    transact(0, 16'd0, 16'h0, 99, 16'h0);
    transact(0, 16'd5, 16'h0, 99, 16'h0);
    // Reset while parked in IO_WAIT: no response, output latch cleared, RAM intact.
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 16'hFFFF;
    repeat (3) begin
      tick();
      chk("wait_no_rsp", RSP_VALID, 0);
    end
    RESET_bar = 1'b0; REQ_VALID = 1'b0;
    repeat (2) begin
      tick();
      chk("rst_mid_quiet", {RSP_VALID, IO_IN_ACK}, 0);
    end
    RESET_bar = 1'b1;
    io_out_m = '0;
    chk("rst_mid_io_out", IO_OUT, 0);
    IO_IN_VALID = 1'b1;
    repeat (2) begin
      tick();
      chk("stray_valid_quiet", {RSP_VALID, IO_IN_ACK}, 0);
    end
    IO_IN_VALID = 1'b0;
    transact(0, 16'd5, 16'h0, 99, 16'h0);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 15));
        1: a = 16'hFFFE;
        2: a = 16'hFFFF;
        default: a = 16'($urandom_range(256, 16'hFFFD));
      endcase
      transact(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 5), 16'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
